// File: rtl/core_pipe_pkg.sv
// Shared pipeline-boundary types for the core: per-stage payload structs and
// the depth limit for core_stage_buf instances.
package core_pipe_pkg;

    localparam int MAX_STAGE_DEPTH = 4;
    localparam int XLEN            = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      reg_idx_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {ASEL_RS1, ASEL_PC, ASEL_ZERO} asel_t;
    typedef enum logic [0:0] {BSEL_RS2, BSEL_IMM} bsel_t;
    typedef enum logic [1:0] {WSEL_ALU, WSEL_MEM, WSEL_PC4, WSEL_CSR} reg_wsel_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } d_payload_t;

    typedef struct packed {
        word_t     pc;
        word_t     rs1_val;
        word_t     rs2_val;
        word_t     imm;
        alu_op_t   alu_op;
        asel_t     asel;
        bsel_t     bsel;
        reg_idx_t  rd;
        reg_wsel_t wsel;
        logic      mem_rd;
        logic      mem_wr;
    } x_payload_t;

    typedef struct packed {
        word_t     pc;
        word_t     alu_res;
        word_t     store_val;
        reg_idx_t  rd;
        reg_wsel_t wsel;
        logic      mem_rd;
        logic      mem_wr;
    } m_payload_t;

    typedef struct packed {
        word_t    wb_val;
        reg_idx_t rd;
        logic     wb_en;
    } w_payload_t;

    // Pointer width for a circular buffer; a single entry still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/core_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; cleared only
// by reset. Shared by the stage buffers and performance counters.
module core_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/core_stage_buf.sv
// Elastic pipeline-stage buffer: circular payload store with flush, hazard
// stall and a saturating count of cycles in which held data was blocked.
module core_stage_buf
    import core_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           bp_cycles
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    if ((DEPTH < 1) || (DEPTH > MAX_STAGE_DEPTH)) begin : g_bad_depth
        $error("core_stage_buf: DEPTH must be within 1..%0d", MAX_STAGE_DEPTH);
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic             bp_inc;

    // Wraps explicitly at DEPTH-1 so non-power-of-two depths cycle correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        out_valid = (count_q != '0) && !stall && !flush;
        // A single-entry buffer must see the same-cycle pop to keep full
        // throughput; deeper buffers decide from occupancy alone.
        if (DEPTH == 1) begin
            in_ready = (count_q == '0) || (out_ready && !stall && !flush);
        end else begin
            in_ready = (count_q < LVL_W'(DEPTH));
        end
        pop    = out_valid && out_ready;
        push   = in_valid && in_ready && !flush;
        bp_inc = (count_q != '0) && (stall || !out_ready) && !flush;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push) begin
                tail_d = ptr_inc(tail_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; only occupancy decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= in_data;
        end
    end

    assign out_data = mem_q[head_q];
    assign level    = count_q;

    core_sat_counter #(
        .W (CNT_W)
    ) u_bp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bp_inc),
        .value (bp_cycles)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_count_bound: assert (count_q <= LVL_W'(DEPTH));
            a_no_overflow: assert (!(push && (count_q == LVL_W'(DEPTH)) && !pop));
        end
    end

endmodule

// File: tb/tb_core_stage_buf.sv
// Bench for core_stage_buf: three instances (DEPTH 2, 1, 3) share stimulus
// and are each compared every cycle against a queue-based reference model.
module tb_core_stage_buf;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        stall;
    logic        flush;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [31:0] od0, od1, od2;
    logic [1:0]  lv0;
    logic [0:0]  lv1;
    logic [1:0]  lv2;
    logic [15:0] bp0, bp1;
    logic [1:0]  bp2;

    core_stage_buf #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .stall(stall),
        .flush(flush), .level(lv0), .bp_cycles(bp0));

    core_stage_buf #(.WIDTH(32), .DEPTH(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .stall(stall),
        .flush(flush), .level(lv1), .bp_cycles(bp1));

    core_stage_buf #(.WIDTH(32), .DEPTH(3), .CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .stall(stall),
        .flush(flush), .level(lv2), .bp_cycles(bp2));

    int          n_vec = 0;
    int          n_err = 0;

    int          dep   [3] = '{2, 1, 3};
    int unsigned bpmax [3] = '{65535, 65535, 3};
    int unsigned mq    [3][$];
    int unsigned mbp   [3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs are already applied at the falling edge; compare, advance the
    // model with those inputs, then move to the next falling edge.
    task automatic step();
        logic [31:0] a_ov, a_od, a_ir, a_lvl, a_bp;
        logic        e_ov, e_ir;
        #1;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin a_ov = 32'(ov0); a_od = od0; a_ir = 32'(ir0); a_lvl = 32'(lv0); a_bp = 32'(bp0); end
                1:       begin a_ov = 32'(ov1); a_od = od1; a_ir = 32'(ir1); a_lvl = 32'(lv1); a_bp = 32'(bp1); end
                default: begin a_ov = 32'(ov2); a_od = od2; a_ir = 32'(ir2); a_lvl = 32'(lv2); a_bp = 32'(bp2); end
            endcase
            e_ov = (mq[k].size() != 0) && !stall && !flush;
            if (dep[k] >= 2) e_ir = (mq[k].size() < dep[k]);
            else             e_ir = (mq[k].size() == 0) || (out_ready && !stall && !flush);
            if (!rst) begin
                check($sformatf("u%0d out_valid", k), a_ov, 32'(e_ov));
                if (e_ov) check($sformatf("u%0d out_data", k), a_od, mq[k][0]);
                check($sformatf("u%0d in_ready", k), a_ir, 32'(e_ir));
                check($sformatf("u%0d level", k), a_lvl, mq[k].size());
                check($sformatf("u%0d bp_cycles", k), a_bp, mbp[k]);
            end
            if (rst) begin
                mq[k].delete();
                mbp[k] = 0;
            end else begin
                if ((mq[k].size() != 0) && (stall || !out_ready) && !flush && (mbp[k] < bpmax[k]))
                    mbp[k]++;
                if (flush) begin
                    mq[k].delete();
                end else begin
                    if (e_ov && out_ready) void'(mq[k].pop_front());
                    if (in_valid && e_ir) mq[k].push_back(in_data);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                         input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        @(negedge clk);

        // Reset for two cycles, then idle.
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        rst = 1'b0;
        check("rst level", 32'(lv0), 0);
        check("rst in_ready", 32'(ir0), 1);
        check("rst out_valid", 32'(ov0), 0);
        check("rst bp", 32'(bp0), 0);
        drive(0, 0, 1, 0, 0);

        // Streaming with out_ready held high.
        drive(1, 32'h11, 1, 0, 0);
        drive(1, 32'h22, 1, 0, 0);
        drive(1, 32'h33, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // Back-pressure: A, B accepted, C held upstream.
        drive(1, 32'hA, 0, 0, 0);
        drive(1, 32'hB, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 32'hC, 0, 0, 0);
        check("bp d2 five", 32'(bp0), 5);
        check("bp d2 level", 32'(lv0), 2);
        drive(1, 32'hC, 1, 0, 0);
        drive(1, 32'hC, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0);

        // Flush with a payload offered in the same cycle.
        drive(1, 32'h66, 0, 0, 0);
        drive(1, 32'h77, 0, 0, 0);
        check("pre-flush level", 32'(lv0), 2);
        drive(1, 32'h55, 0, 0, 1);
        check("post-flush level", 32'(lv0), 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);

        // Stall toggled every two cycles across pointer wrap.
        for (int i = 0; i < 20; i++) drive(1, 32'(i + 1), 1, ((i / 2) % 2) == 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);

        // Saturation of the narrow counter.
        for (int i = 0; i < 8; i++) drive(1, 32'h99, 0, 0, 0);
        check("bp d3 saturated", 32'(bp2), 3);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
